// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Synchronise and debounce the pedestrian push-button, then turn
//            each clean press into a held request with a post-ack cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int COOLDOWN = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       ack,
    output logic       btn_req,
    output logic       btn_clean,
    output logic       press_pulse,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_cd_cnt;
    logic [CNT_W-1:0] w_cd_next;
    state_t           r_state;
    state_t           w_state_next;
    logic             w_req_next;
    logic             w_db_done;
    logic             w_rise;

    // The pending level change is committed on the DEBOUNCE-th disagreeing sample.
    assign w_db_done = (r_s2 != btn_clean) && (r_db_cnt == DB_LAST);
    assign w_rise    = w_db_done && r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_db_cnt    <= '0;
            btn_clean   <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            r_s1        <= btn_raw;
            r_s2        <= r_s1;
            press_pulse <= w_rise;
            if (r_s2 == btn_clean) begin
                r_db_cnt <= '0;
            end else if (w_db_done) begin
                btn_clean <= r_s2;
                r_db_cnt  <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            btn_req  <= 1'b0;
            r_cd_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            btn_req  <= w_req_next;
            r_cd_cnt <= w_cd_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_next   = btn_req;
        w_cd_next    = r_cd_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_PENDING;
                    w_req_next   = 1'b1;
                end
            end
            ST_PENDING: begin
                // Extra presses while waiting are absorbed into the open request.
                if (ack) begin
                    w_state_next = ST_COOLDOWN;
                    w_req_next   = 1'b0;
                    w_cd_next    = CD_LAST;
                end
            end
            ST_COOLDOWN: begin
                w_req_next = 1'b0;
                if (r_cd_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cd_next = r_cd_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Directed scenarios plus randomized bouncing input for btn_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int DEBOUNCE = 4;
    localparam int COOLDOWN = 8;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       ack;
    logic       btn_req;
    logic       btn_clean;
    logic       press_pulse;
    logic [1:0] state;

    int checks;
    int passed;

    btn_conditioner #(.DEBOUNCE(DEBOUNCE), .COOLDOWN(COOLDOWN), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .ack        (ack),
        .btn_req    (btn_req),
        .btn_clean  (btn_clean),
        .press_pulse(press_pulse),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw history gives the synchronised sample, and the clean
    // level flips once the last DEBOUNCE samples all disagree with it.
    logic       raw_q[$];
    logic       s2_q[$];
    logic       m_req, m_clean, m_pulse;
    logic [1:0] m_state;
    int         m_cd_left;

    logic [4:0] obs;
    logic [4:0] exp_v;
    assign obs   = {btn_req, btn_clean, press_pulse, state};
    assign exp_v = {m_req, m_clean, m_pulse, m_state};

    task automatic model_edge();
        logic s2, flip, rise;
        if (reset) begin
            raw_q.delete();
            s2_q.delete();
            m_req = 0; m_clean = 0; m_pulse = 0; m_state = 2'd0; m_cd_left = 0;
        end else begin
            s2 = (raw_q.size() == 2) ? raw_q[0] : 1'b0;
            raw_q.push_back(btn_raw);
            if (raw_q.size() > 2) void'(raw_q.pop_front());
            s2_q.push_back(s2);
            if (s2_q.size() > DEBOUNCE) void'(s2_q.pop_front());
            flip = (s2_q.size() == DEBOUNCE);
            foreach (s2_q[k]) if (s2_q[k] == m_clean) flip = 1'b0;
            rise = flip && !m_clean;
            if (flip) m_clean = !m_clean;
            m_pulse = rise;
            case (m_state)
                2'd0: if (rise) begin m_state = 2'd1; m_req = 1'b1; end
                2'd1: if (ack) begin m_state = 2'd2; m_req = 1'b0; m_cd_left = COOLDOWN; end
                default: begin
                    m_cd_left = m_cd_left - 1;
                    if (m_cd_left == 0) m_state = 2'd0;
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_raw = 1'b1; ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== 5'b0) $display("FAIL reset cyc%0d got=%b want=00000", i, obs);
            else passed++;
        end
    endtask

    task automatic test_press();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (obs !== exp_v) $display("FAIL press_model e%0d got=%b want=%b", i, obs, exp_v);
            else passed++;
            if (i == 4) begin
                checks++;
                if (obs !== 5'b00000) $display("FAIL press_early got=%b want=00000", obs);
                else passed++;
            end
            if (i == 5) begin
                checks++;
                if (obs !== 5'b11101) $display("FAIL press_e5 got=%b want=11101", obs);
                else passed++;
            end
            if (i == 6) begin
                checks++;
                if (obs !== 5'b11001) $display("FAIL press_e6 got=%b want=11001", obs);
                else passed++;
            end
        end
    endtask

    task automatic test_ack_cooldown();
        int  cd_cycles;
        bit  saw_pulse, saw_req;
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs !== exp_v) $display("FAIL release_model c%0d got=%b want=%b", i, obs, exp_v);
            else passed++;
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if ({btn_req, state} !== 3'b010) $display("FAIL ack_enter got=%b want=010", {btn_req, state});
        else passed++;
        cd_cycles = 1; saw_pulse = 0; saw_req = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs !== exp_v) $display("FAIL cooldown_model c%0d got=%b want=%b", i, obs, exp_v);
            else passed++;
            if (state != 2'd2) break;
            cd_cycles++;
            saw_pulse |= press_pulse;
            saw_req   |= btn_req;
        end
        checks++;
        if (cd_cycles != COOLDOWN) $display("FAIL cooldown_len got=%0d want=%0d", cd_cycles, COOLDOWN);
        else passed++;
        checks++;
        if ({saw_pulse, saw_req} !== 2'b10) $display("FAIL cooldown_press pulse,req got=%b want=10", {saw_pulse, saw_req});
        else passed++;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({btn_req, state} !== 3'b000) $display("FAIL held_no_rereq got=%b want=000", {btn_req, state});
        else passed++;
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) step();
        btn_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs !== exp_v) $display("FAIL repress_model c%0d got=%b want=%b", i, obs, exp_v);
            else passed++;
        end
        checks++;
        if ({btn_req, state} !== 3'b101) $display("FAIL repress_req got=%b want=101", {btn_req, state});
        else passed++;
    endtask

    task automatic test_back_to_back();
        btn_raw = 1'b0;
        for (int i = 0; i < 8; i++) step();
        btn_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({btn_req, state} !== 3'b101) $display("FAIL double_press c%0d got=%b want=101", i, {btn_req, state});
            else passed++;
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if ({btn_req, state} !== 3'b010) $display("FAIL single_ack got=%b want=010", {btn_req, state});
        else passed++;
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) step();
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({btn_req, btn_clean, state} !== 4'b0000) $display("FAIL idle_ack c%0d got=%b want=0000", i, {btn_req, btn_clean, state});
            else passed++;
        end
        ack = 1'b0;
        btn_raw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ack = (i == 5);
            step();
            checks++;
            if (obs !== exp_v) $display("FAIL rise_ack_model e%0d got=%b want=%b", i, obs, exp_v);
            else passed++;
        end
        ack = 1'b0;
        checks++;
        if ({btn_req, state} !== 3'b101) $display("FAIL rise_with_ack got=%b want=101", {btn_req, state});
        else passed++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        btn_raw = 1'b0;
        for (int i = 0; i < 14; i++) step();
    endtask

    task automatic test_bounce();
        logic pat[14] = '{1,1,1,0,1,1,1,0,0,0,0,0,0,0};
        bit   bad;
        bad = 0;
        foreach (pat[i]) begin
            btn_raw = pat[i];
            step();
            checks++;
            if (obs !== exp_v) $display("FAIL bounce_model c%0d got=%b want=%b", i, obs, exp_v);
            else passed++;
            bad |= (btn_clean | press_pulse | (state != 2'd0));
        end
        checks++;
        if (bad) $display("FAIL bounce_reject got=glitch want=quiet");
        else passed++;
    endtask

    task automatic test_reset_mid();
        int idx;
        btn_raw = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (state !== 2'd1) $display("FAIL mid_pending got=%0d want=1", state);
        else passed++;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== 5'b0) $display("FAIL mid_reset c%0d got=%b want=00000", i, obs);
            else passed++;
        end
        reset = 1'b0;
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (idx < 0 && btn_req && btn_clean) idx = i;
        end
        checks++;
        if (idx != 5) $display("FAIL reset_rerequest edge got=%0d want=5", idx);
        else passed++;
        ack = 1'b1;
        step();
        ack = 1'b0;
        btn_raw = 1'b0;
        for (int i = 0; i < 14; i++) step();
    endtask

    task automatic test_random();
        int run;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                btn_raw = 1'($urandom_range(0, 1));
                run = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 20) : $urandom_range(1, 4);
            end
            run--;
            ack   = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 399) == 0);
            step();
            checks++;
            if (obs !== exp_v) $display("FAIL random c%0d got=%b want=%b", i, obs, exp_v);
            else passed++;
        end
        reset = 1'b0;
        ack = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset = 1'b1; btn_raw = 1'b0; ack = 1'b0;
        test_reset();
        test_press();
        test_ack_cooldown();
        test_back_to_back();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
